hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage xgriscv datapath: drives stall/flush enables of F/D/E/M/W regs,

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_fwd_sel.sv | 33 +++
 rtl/hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared constants for the xgriscv hazard sequencer: EX/D forward-select
//   codes and the data-memory wait FSM state encoding.
//   No ports (package).
package hazard_ctrl_pkg;

  // Operand source selects for the EX-stage forward muxes
  localparam logic [1:0] FWD_RF = 2'b00;  // register file read
  localparam logic [1:0] FWD_W  = 2'b01;  // writeback result
  localparam logic [1:0] FWD_M  = 2'b10;  // memory-stage ALU result

  // Data-memory wait FSM
  typedef enum logic {
    HZ_IDLE = 1'b0,
    HZ_WAIT = 1'b1
  } hzState_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel
//   Combinational forward-source select for one source operand. The M stage
//   has priority over W because it holds the younger write. x0 never matches.
// Ports
//   rs         in  RFIDX_WIDTH  source register being read
//   rdM        in  RFIDX_WIDTH  destination of instr in M
//   regwriteM  in  1            instr in M writes rdM
//   rdW        in  RFIDX_WIDTH  destination of instr in W
//   regwriteW  in  1            instr in W writes rdW
//   sel        out 2            FWD_RF / FWD_W / FWD_M
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int RFIDX_WIDTH = 5
) (
  input  logic [RFIDX_WIDTH-1:0] rs,
  input  logic [RFIDX_WIDTH-1:0] rdM,
  input  logic                   regwriteM,
  input  logic [RFIDX_WIDTH-1:0] rdW,
  input  logic                   regwriteW,
  output logic [1:0]             sel
);

  always_comb begin
    sel = FWD_RF;
    if (regwriteM && (rdM != '0) && (rdM == rs)) begin
      sel = FWD_M;
    end else if (regwriteW && (rdW != '0) && (rdW == rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline sequencer for the 5-stage xgriscv datapath. Drives stall/flush
//   enables of the F/D/E/M/W stage registers, selects EX operand forwarding
//   and D-stage branch-compare forwarding, inserts load-use / branch-operand
//   bubbles and freezes the pipe while data memory is busy.
//
//   state   | meaning
//   HZ_IDLE | no outstanding memory wait
//   HZ_WAIT | memreqM outstanding, waiting for memackM (bounded by MEM_TMO)
//
// Configuration macro: HAZARD_PERF_EN adds saturating stall_cnt/flush_cnt
// outputs (width CNT_W). Without it those ports and flops do not exist.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   rs1D, rs2D, use1D, use2D      decode source regs and their use flags
//   branchD, pcsrcD               D-stage compare instr, taken redirect
//   rs1E, rs2E, rdE               execute regs; regwriteE, memtoregE
//   rdM, regwriteM, memtoregM     memory-stage dest; memreqM, memackM
//   rdW, regwriteW                writeback dest
//   stallF/D/E/M, flushD/E/W      stage register hold / bubble enables
//   fwdaE, fwdbE                  EX operand forward selects
//   fwdaD, fwdbD                  D compare forward (1 = aluoutM)
//   stall_cnt, flush_cnt          perf counters (HAZARD_PERF_EN only)
//   mem_err                       sticky memory-timeout flag (registered)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RFIDX_WIDTH = 5,
  parameter int MEM_TMO     = 16
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RFIDX_WIDTH-1:0] rs1D,
  input  logic [RFIDX_WIDTH-1:0] rs2D,
  input  logic                   use1D,
  input  logic                   use2D,
  input  logic                   branchD,
  input  logic                   pcsrcD,
  input  logic [RFIDX_WIDTH-1:0] rs1E,
  input  logic [RFIDX_WIDTH-1:0] rs2E,
  input  logic [RFIDX_WIDTH-1:0] rdE,
  input  logic                   regwriteE,
  input  logic                   memtoregE,
  input  logic [RFIDX_WIDTH-1:0] rdM,
  input  logic                   regwriteM,
  input  logic                   memtoregM,
  input  logic                   memreqM,
  input  logic                   memackM,
  input  logic [RFIDX_WIDTH-1:0] rdW,
  input  logic                   regwriteW,
  output logic                   stallF,
  output logic                   stallD,
  output logic                   stallE,
  output logic                   stallM,
  output logic                   flushD,
  output logic                   flushE,
  output logic                   flushW,
  output logic [1:0]             fwdaE,
  output logic [1:0]             fwdbE,
  output logic                   fwdaD,
  output logic                   fwdbD,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt,
`endif
  output logic                   mem_err
);

  // Wait timer counts down from MEM_TMO-2: the IDLE cycle that raises the
  // request is the first stall cycle, so WAIT lasts at most MEM_TMO-1 cycles.
  localparam int            CW       = (MEM_TMO > 2) ? $clog2(MEM_TMO - 1) : 1;
  localparam logic [CW-1:0] TMO_LOAD = CW'(MEM_TMO - 2);

  hzState_t      state;
  logic [CW-1:0] waitCnt;

  logic       memWait;
  logic       ldUse;
  logic       brHaz;
  logic       hz;
  logic [1:0] selAE, selBE, selAD, selBD;

  function automatic logic hit(input logic [RFIDX_WIDTH-1:0] rd,
                               input logic [RFIDX_WIDTH-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

  hazard_fwd_sel #(.RFIDX_WIDTH(RFIDX_WIDTH)) uFwdAE (
    .rs(rs1E), .rdM(rdM), .regwriteM(regwriteM),
    .rdW(rdW), .regwriteW(regwriteW), .sel(selAE)
  );
  hazard_fwd_sel #(.RFIDX_WIDTH(RFIDX_WIDTH)) uFwdBE (
    .rs(rs2E), .rdM(rdM), .regwriteM(regwriteM),
    .rdW(rdW), .regwriteW(regwriteW), .sel(selBE)
  );

  // D compare only takes aluoutM; a load result in M is not ready yet, and W
  // is already visible through the register file.
  hazard_fwd_sel #(.RFIDX_WIDTH(RFIDX_WIDTH)) uFwdAD (
    .rs(rs1D), .rdM(rdM), .regwriteM(regwriteM && !memtoregM),
    .rdW('0), .regwriteW(1'b0), .sel(selAD)
  );
  hazard_fwd_sel #(.RFIDX_WIDTH(RFIDX_WIDTH)) uFwdBD (
    .rs(rs2D), .rdM(rdM), .regwriteM(regwriteM && !memtoregM),
    .rdW('0), .regwriteW(1'b0), .sel(selBD)
  );

  assign ldUse = memtoregE && ((use1D && hit(rdE, rs1D)) || (use2D && hit(rdE, rs2D)));
  assign brHaz = branchD &&
                 ((regwriteE && (hit(rdE, rs1D) || hit(rdE, rs2D))) ||
                  (memtoregM && (hit(rdM, rs1D) || hit(rdM, rs2D))));
  assign hz    = ldUse || brHaz;

  // Stall starts in the request cycle; released in the ack cycle.
  assign memWait = (state == HZ_IDLE) ? (memreqM && !memackM) : !memackM;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= HZ_IDLE;
      waitCnt <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        HZ_IDLE: begin
          if (memreqM && !memackM) begin
            state   <= HZ_WAIT;
            waitCnt <= TMO_LOAD;
          end
        end
        HZ_WAIT: begin
          if (memackM) begin
            state   <= HZ_IDLE;
            waitCnt <= '0;
          end else if (waitCnt == '0) begin
            state   <= HZ_IDLE;
            mem_err <= 1'b1;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        default: state <= HZ_IDLE;
      endcase
    end
  end

  // Freeze overrides hazard bubbles; a taken redirect waits until the
  // stall clears so the fetch it kills is the wrong-path one.
  assign stallF = !reset && (memWait || hz);
  assign stallD = !reset && (memWait || hz);
  assign stallE = !reset && memWait;
  assign stallM = !reset && memWait;
  assign flushW = !reset && memWait;
  assign flushE = !reset && !memWait && hz;
  assign flushD = !reset && !memWait && !hz && pcsrcD;
  assign fwdaE  = reset ? FWD_RF : selAE;
  assign fwdbE  = reset ? FWD_RF : selBE;
  assign fwdaD  = !reset && (selAD == FWD_M);
  assign fwdbD  = !reset && (selBD == FWD_M);

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallF && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if ((flushD || flushE) && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MEM_TMO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       use1D, use2D, branchD, pcsrcD;
  logic       regwriteE, memtoregE, regwriteM, memtoregM, memreqM, memackM, regwriteW;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [1:0] fwdaE, fwdbE;
  logic       fwdaD, fwdbD, mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  int unsigned mStallCnt, mFlushCnt;
`endif

  int nChecks = 0;
  int nErr    = 0;

  // reference model state
  logic mInWait, mErr;
  int   mElapsed;

  always #5 clk = ~clk;

  hazard_ctrl #(.RFIDX_WIDTH(5), .MEM_TMO(MEM_TMO)) dut (
    .clk(clk), .reset(reset),
    .rs1D(rs1D), .rs2D(rs2D), .use1D(use1D), .use2D(use2D),
    .branchD(branchD), .pcsrcD(pcsrcD),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .regwriteE(regwriteE), .memtoregE(memtoregE),
    .rdM(rdM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .memreqM(memreqM), .memackM(memackM),
    .rdW(rdW), .regwriteW(regwriteW),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .fwdaE(fwdaE), .fwdbE(fwdbE), .fwdaD(fwdaD), .fwdbD(fwdbD),
`ifdef HAZARD_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .mem_err(mem_err)
  );

  wire [12:0] dutOut = {stallF, stallD, stallE, stallM, flushD, flushE, flushW,
                        fwdaE, fwdbE, fwdaD, fwdbD};

  function automatic logic [12:0] mk(input logic sf, sd, se, sm, fd, fe, fw,
                                     input logic [1:0] fa, fb,
                                     input logic fad, fbd);
    return {sf, sd, se, sm, fd, fe, fw, fa, fb, fad, fbd};
  endfunction

  function automatic logic [1:0] pickE(input logic [4:0] rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs from the current inputs and model wait state.
  function automatic logic [12:0] refOut();
    logic mw, lu, bh, h, fad, fbd;
    if (reset) return '0;
    mw  = mInWait ? !memackM : (memreqM && !memackM);
    lu  = memtoregE && rdE != 0 &&
          ((use1D && rs1D == rdE) || (use2D && rs2D == rdE));
    bh  = branchD && ((regwriteE && rdE != 0 && (rdE == rs1D || rdE == rs2D)) ||
                      (memtoregM && rdM != 0 && (rdM == rs1D || rdM == rs2D)));
    h   = lu || bh;
    fad = regwriteM && !memtoregM && rdM != 0 && rdM == rs1D;
    fbd = regwriteM && !memtoregM && rdM != 0 && rdM == rs2D;
    return mk(h | mw, h | mw, mw, mw, pcsrcD & !h & !mw, h & !mw, mw,
              pickE(rs1E), pickE(rs2E), fad, fbd);
  endfunction

  // Wait model: elapsed counts stall cycles of the current wait, including
  // the request cycle; reaching MEM_TMO without ack is a timeout.
  always @(posedge clk) begin
`ifdef HAZARD_PERF_EN
    logic [12:0] e;
    e = refOut();
    if (reset) begin
      mStallCnt <= 0; mFlushCnt <= 0;
    end else begin
      if (e[12] && mStallCnt != 32'hFFFF_FFFF) mStallCnt <= mStallCnt + 1;
      if ((e[8] || e[7]) && mFlushCnt != 32'hFFFF_FFFF) mFlushCnt <= mFlushCnt + 1;
    end
`endif
    if (reset) begin
      mInWait <= 1'b0; mElapsed <= 0; mErr <= 1'b0;
    end else if (!mInWait) begin
      if (memreqM && !memackM) begin mInWait <= 1'b1; mElapsed <= 1; end
    end else if (memackM) begin
      mInWait <= 1'b0;
    end else if (mElapsed + 1 == MEM_TMO) begin
      mInWait <= 1'b0; mErr <= 1'b1;
    end else begin
      mElapsed <= mElapsed + 1;
    end
  end

  task automatic clr();
    reset = 0; rs1D = 0; rs2D = 0; use1D = 0; use2D = 0; branchD = 0; pcsrcD = 0;
    rs1E = 0; rs2E = 0; rdE = 0; regwriteE = 0; memtoregE = 0;
    rdM = 0; regwriteM = 0; memtoregM = 0; memreqM = 0; memackM = 0;
    rdW = 0; regwriteW = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clr(); reset = 1;
    rs1D = 3; use1D = 1; branchD = 1; pcsrcD = 1; rdE = 3; regwriteE = 1; memtoregE = 1;
    rs1E = 4; rdM = 4; regwriteM = 1; memreqM = 1; rdW = 4; regwriteW = 1;
    #1;
    nChecks++;
    if (dutOut !== 13'd0) begin
      nErr++; $display("FAIL reset_outputs: got %b expected %b", dutOut, 13'd0);
    end
    @(negedge clk); #1;
    nChecks++;
    if (mem_err !== 1'b0) begin
      nErr++; $display("FAIL reset_mem_err: got %b expected 0", mem_err);
    end
    @(negedge clk); clr(); #1;
    nChecks++;
    if (dutOut !== 13'd0) begin
      nErr++; $display("FAIL idle_outputs: got %b expected %b", dutOut, 13'd0);
    end
  endtask

  task automatic test_fwd();
    logic [12:0] exp [4];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); clr();
      case (i)
        0: begin regwriteM = 1; rdM = 5; rs1E = 5; exp[i] = mk(0,0,0,0,0,0,0,2'b10,2'b00,0,0); end
        1: begin regwriteM = 1; rdM = 0; rs1E = 0; exp[i] = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0); end
        2: begin regwriteM = 1; rdM = 7; regwriteW = 1; rdW = 7; rs2E = 7;
                 exp[i] = mk(0,0,0,0,0,0,0,2'b00,2'b10,0,0); end
        default: begin rdM = 7; regwriteW = 1; rdW = 7; rs2E = 7;
                 exp[i] = mk(0,0,0,0,0,0,0,2'b00,2'b01,0,0); end
      endcase
      #1;
      nChecks++;
      if (dutOut !== exp[i]) begin
        nErr++; $display("FAIL fwd_case%0d: got %b expected %b", i, dutOut, exp[i]);
      end
    end
  endtask

  task automatic test_lduse();
    logic [12:0] exp [4];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); clr();
      case (i)
        0: begin memtoregE = 1; regwriteE = 1; rdE = 3; rs1D = 3; use1D = 1;
                 exp[i] = mk(1,1,0,0,0,1,0,2'b00,2'b00,0,0); end
        1: begin regwriteM = 1; memtoregM = 1; rdM = 3; rs1D = 3; use1D = 1;
                 exp[i] = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0); end
        2: begin memtoregE = 1; regwriteE = 1; rdE = 3; rs1D = 3; use1D = 0;
                 exp[i] = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0); end
        default: begin memtoregE = 1; regwriteE = 1; rdE = 0; rs2D = 0; use2D = 1;
                 exp[i] = mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0); end
      endcase
      #1;
      nChecks++;
      if (dutOut !== exp[i]) begin
        nErr++; $display("FAIL lduse_step%0d: got %b expected %b", i, dutOut, exp[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [12:0] exp [6];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); clr();
      branchD = 1; rs1D = 4; use1D = 1;
      case (i)
        0: begin regwriteE = 1; rdE = 4; exp[i] = mk(1,1,0,0,0,1,0,2'b00,2'b00,0,0); end
        1: begin regwriteM = 1; rdM = 4; exp[i] = mk(0,0,0,0,0,0,0,2'b00,2'b00,1,0); end
        2: begin regwriteE = 1; memtoregE = 1; rdE = 4;
                 exp[i] = mk(1,1,0,0,0,1,0,2'b00,2'b00,0,0); end
        3: begin regwriteM = 1; memtoregM = 1; rdM = 4;
                 exp[i] = mk(1,1,0,0,0,1,0,2'b00,2'b00,0,0); end
        4: begin regwriteW = 1; rdW = 4; pcsrcD = 1;
                 exp[i] = mk(0,0,0,0,1,0,0,2'b00,2'b00,0,0); end
        default: begin regwriteE = 1; rdE = 4; pcsrcD = 1;
                 exp[i] = mk(1,1,0,0,0,1,0,2'b00,2'b00,0,0); end
      endcase
      #1;
      nChecks++;
      if (dutOut !== exp[i]) begin
        nErr++; $display("FAIL branch_step%0d: got %b expected %b", i, dutOut, exp[i]);
      end
    end
  endtask

  task automatic test_memwait();
    logic [12:0] exp;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); clr();
      if (i < 4) begin
        memreqM = 1; memackM = (i == 3);
        memtoregE = 1; regwriteE = 1; rdE = 3; rs1D = 3; use1D = 1; pcsrcD = 1;
      end
      if (i < 3)       exp = mk(1,1,1,1,0,0,1,2'b00,2'b00,0,0);
      else if (i == 3) exp = mk(1,1,0,0,0,1,0,2'b00,2'b00,0,0);
      else             exp = '0;
      #1;
      nChecks++;
      if (dutOut !== exp) begin
        nErr++; $display("FAIL memwait_cycle%0d: got %b expected %b", i, dutOut, exp);
      end
    end
    nChecks++;
    if (mem_err !== 1'b0) begin
      nErr++; $display("FAIL memwait_no_err: got %b expected 0", mem_err);
    end
  endtask

  task automatic test_timeout();
    int stalls = 0;
    bit errEarly = 0;
    for (int i = 0; i < MEM_TMO; i++) begin
      @(negedge clk); clr(); memreqM = 1; #1;
      if (stallM === 1'b1 && flushW === 1'b1) stalls++;
      if (mem_err !== 1'b0) errEarly = 1;
    end
    @(negedge clk); clr(); #1;
    nChecks++;
    if (stalls != MEM_TMO || errEarly) begin
      nErr++; $display("FAIL timeout_stalls: got %0d early_err=%0d expected %0d early_err=0",
                       stalls, errEarly, MEM_TMO);
    end
    nChecks++;
    if (dutOut !== 13'd0 || mem_err !== 1'b1) begin
      nErr++; $display("FAIL timeout_release: got out=%b err=%b expected out=0 err=1", dutOut, mem_err);
    end
    repeat (3) @(negedge clk);
    #1;
    nChecks++;
    if (mem_err !== 1'b1) begin
      nErr++; $display("FAIL timeout_sticky: got %b expected 1", mem_err);
    end
    // reset while waiting: enter WAIT, then reset, then idle inputs
    @(negedge clk); clr(); memreqM = 1;
    @(negedge clk); #1;
    nChecks++;
    if (stallE !== 1'b1) begin
      nErr++; $display("FAIL wait_entered: got %b expected 1", stallE);
    end
    @(negedge clk); reset = 1; #1;
    nChecks++;
    if (dutOut !== 13'd0) begin
      nErr++; $display("FAIL reset_mid_wait_out: got %b expected %b", dutOut, 13'd0);
    end
    @(negedge clk); clr(); #1;
    nChecks++;
    if (dutOut !== 13'd0 || mem_err !== 1'b0) begin
      nErr++; $display("FAIL reset_mid_wait_state: got out=%b err=%b expected out=0 err=0", dutOut, mem_err);
    end
  endtask

  task automatic test_random();
    logic [12:0] exp;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        reset     = ($urandom_range(0, 63) == 0);
        rs1D      = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
        use1D     = 1'($urandom); use2D = 1'($urandom);
        branchD   = 1'($urandom); pcsrcD = 1'($urandom);
        rs1E      = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
        rdE       = 5'($urandom_range(0, 3));
        regwriteE = 1'($urandom); memtoregE = 1'($urandom);
        rdM       = 5'($urandom_range(0, 3));
        regwriteM = 1'($urandom); memtoregM = 1'($urandom);
        memreqM   = ($urandom_range(0, 2) == 0);
        memackM   = (ph == 0) ? 1'($urandom) : ($urandom_range(0, 7) == 0);
        rdW       = 5'($urandom_range(0, 3)); regwriteW = 1'($urandom);
        #1;
        exp = refOut();
        nChecks++;
        if (dutOut !== exp) begin
          nErr++; $display("FAIL random_out ph%0d i%0d: got %b expected %b", ph, i, dutOut, exp);
        end
        nChecks++;
        if (mem_err !== mErr) begin
          nErr++; $display("FAIL random_mem_err ph%0d i%0d: got %b expected %b", ph, i, mem_err, mErr);
        end
      end
    end
`ifdef HAZARD_PERF_EN
    @(negedge clk); #1;
    nChecks++;
    if (stall_cnt !== mStallCnt || flush_cnt !== mFlushCnt) begin
      nErr++; $display("FAIL perf_counts: got %0d/%0d expected %0d/%0d",
                       stall_cnt, flush_cnt, mStallCnt, mFlushCnt);
    end
`endif
  endtask

  initial begin
    clr();
    reset = 1;
    repeat (2) @(posedge clk);
    test_reset();
    test_fwd();
    test_lduse();
    test_branch();
    test_memwait();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
